simple4_mem_arbiter: RTL and testbench

Shares the single-port 16×4 data RAM of the simple4 processor between two requesters: port 0 is the core FSM (LOAD/STORE phases), port 1 is the program/debug loader. The block provides round-robin arbitration, a lock that makes read-modify-write sequences (ADD/SUB/NOT) atomic, and a lock watchdog. It sits between the requesters and the RAM instance, and is the only driver of the RAM control pins.

---
 rtl/simple4_pkg.sv | 12 +
 rtl/arb_rr2.sv | 19 +
 rtl/simple4_mem_arbiter.sv | 103 ++++++++++
 tb/tb_simple4_mem_arbiter.sv | 185 ++++++++++++++++++
 4 files changed

// File: rtl/simple4_pkg.sv
// Shared widths, requester indices and data types for the simple4 memory path.
package simple4_pkg;

  localparam int ADDR_W     = 4;
  localparam int DATA_W     = 4;
  localparam int REQ_CORE   = 0;
  localparam int REQ_LOADER = 1;

  typedef logic [ADDR_W-1:0] addr_t;
  typedef logic [DATA_W-1:0] data_t;

endpackage

// File: rtl/arb_rr2.sv
// Two-input round-robin picker: a tie goes to the port not served last.
module arb_rr2
  import simple4_pkg::*;
(
  input  logic [1:0] req,
  input  logic       last,
  output logic [1:0] pick
);

  always_comb begin
    // NOTE: every output gets a default first so no path leaves it unassigned (no latch).
    pick = req;
    if (req[REQ_CORE] && req[REQ_LOADER]) begin
      pick[REQ_CORE]   = last;
      pick[REQ_LOADER] = ~last;
    end
  end

endmodule

// File: rtl/simple4_mem_arbiter.sv
// Arbitrates the single-port data RAM between the core FSM and the loader,
// with an atomic-access lock and a watchdog that breaks a lock held too long.
module simple4_mem_arbiter #(
  parameter int ADDR_W   = simple4_pkg::ADDR_W,
  parameter int DATA_W   = simple4_pkg::DATA_W,
  parameter int LOCK_MAX = 8
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [1:0]        req,
  input  logic [1:0]        lock,
  input  logic [1:0]        we,
  input  logic [ADDR_W-1:0] addr0,
  input  logic [ADDR_W-1:0] addr1,
  input  logic [DATA_W-1:0] wdata0,
  input  logic [DATA_W-1:0] wdata1,
  output logic [1:0]        gnt,
  output logic [1:0]        rvalid,
  output logic [DATA_W-1:0] rdata,
  output logic              lock_err,
  output logic              ram_en,
  output logic              ram_we,
  output logic [ADDR_W-1:0] ram_addr,
  output logic [DATA_W-1:0] ram_wdata,
  input  logic [DATA_W-1:0] ram_rdata
);

  localparam int               CNT_W    = (LOCK_MAX > 1) ? $clog2(LOCK_MAX) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(LOCK_MAX - 1);

  logic             owner_vld;
  logic             owner;
  logic             last;
  logic [CNT_W-1:0] lock_cnt;
  logic [1:0]       rd_pend;

  logic [1:0] elig;
  logic [1:0] pick;
  logic       g;
  logic       any_gnt;
  logic       own_rel;
  logic       wd_fire;

  // While locked only the owner is eligible; idle owner cycles still count.
  always_comb begin
    elig = req;
    if (owner_vld) elig = req & (owner ? 2'b10 : 2'b01);
  end

  arb_rr2 u_arb (
    .req  (elig),
    .last (last),
    .pick (pick)
  );

  assign gnt     = reset ? 2'b00 : pick;
  assign any_gnt = |gnt;
  assign g       = gnt[simple4_pkg::REQ_LOADER];

  // Any grant while locked is the owner's; releasing beats the watchdog.
  assign own_rel = owner_vld && any_gnt && !lock[g];
  assign wd_fire = owner_vld && (lock_cnt == CNT_LAST) && !own_rel;

  always_comb begin
    ram_en    = any_gnt;
    ram_we    = 1'b0;
    ram_addr  = '0;
    ram_wdata = '0;
    if (any_gnt) begin
      ram_we    = we[g];
      ram_addr  = g ? addr1 : addr0;
      ram_wdata = g ? wdata1 : wdata0;
    end
  end

  assign rvalid = reset ? 2'b00 : rd_pend;
  assign rdata  = ram_rdata;

  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    if (reset) begin
      owner_vld <= 1'b0;
      owner     <= 1'b0;
      last      <= 1'b1;
      lock_cnt  <= '0;
      rd_pend   <= 2'b00;
      lock_err  <= 1'b0;
    end else begin
      lock_err <= wd_fire;
      rd_pend  <= gnt & ~we;
      if (any_gnt) last <= g;
      if (owner_vld) begin
        if (own_rel || wd_fire) owner_vld <= 1'b0;
        else if (lock_cnt != '1) lock_cnt <= lock_cnt + CNT_W'(1);
      end else if (any_gnt && lock[g]) begin
        owner_vld <= 1'b1;
        owner     <= g;
        lock_cnt  <= '0;
      end
    end
  end

endmodule

// File: tb/tb_simple4_mem_arbiter.sv
// Directed bench for simple4_mem_arbiter with a behavioural 16x4 synchronous RAM.
module tb_simple4_mem_arbiter;

  logic       clk = 1'b0;
  logic       reset;
  logic [1:0] req, lock, we;
  logic [3:0] addr0, addr1, wdata0, wdata1;
  logic [1:0] gnt, rvalid;
  logic [3:0] rdata, ram_addr, ram_wdata, ram_rdata;
  logic       lock_err, ram_en, ram_we;

  logic [3:0] mem [16];

  int n_vec = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  simple4_mem_arbiter #(.ADDR_W(4), .DATA_W(4), .LOCK_MAX(8)) dut (
    .clk       (clk),
    .reset     (reset),
    .req       (req),
    .lock      (lock),
    .we        (we),
    .addr0     (addr0),
    .addr1     (addr1),
    .wdata0    (wdata0),
    .wdata1    (wdata1),
    .gnt       (gnt),
    .rvalid    (rvalid),
    .rdata     (rdata),
    .lock_err  (lock_err),
    .ram_en    (ram_en),
    .ram_we    (ram_we),
    .ram_addr  (ram_addr),
    .ram_wdata (ram_wdata),
    .ram_rdata (ram_rdata)
  );

  always @(posedge clk) begin
    if (ram_en) begin
      if (ram_we) mem[ram_addr] <= ram_wdata;
      else        ram_rdata     <= mem[ram_addr];
    end
  end

  task automatic check(input string tag, input logic [7:0] got, input logic [7:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Drive one cycle of stimulus after the falling edge, then settle before checking.
  task automatic cyc(input logic rst, input logic [1:0] r, input logic [1:0] l,
                     input logic [1:0] w, input logic [3:0] a0, input logic [3:0] d0,
                     input logic [3:0] a1, input logic [3:0] d1);
    @(negedge clk);
    reset = rst; req = r; lock = l; we = w;
    addr0 = a0; wdata0 = d0; addr1 = a1; wdata1 = d1;
    #1;
  endtask

  initial begin
    for (int i = 0; i < 16; i++) mem[i] = 4'h0;
    mem[4] = 4'h5;
    mem[5] = 4'hA;
    mem[6] = 4'h7;
    ram_rdata = 4'h0;

    // Reset state, with both ports requesting writes that must be suppressed
    cyc(1, 2'b11, 2'b00, 2'b11, 4'd4, 4'h9, 4'd5, 4'h9);
    check("rst_gnt", gnt, 2'b00);
    check("rst_rvalid", rvalid, 2'b00);
    check("rst_lock_err", lock_err, 1'b0);
    check("rst_ram_en", ram_en, 1'b0);
    check("rst_ram_we", ram_we, 1'b0);
    check("rst_ram_addr", ram_addr, 4'd0);
    check("rst_ram_wdata", ram_wdata, 4'd0);

    // Single read after reset
    cyc(0, 2'b01, 2'b00, 2'b00, 4'd4, 4'h0, 4'd0, 4'h0);
    check("rd_gnt", gnt, 2'b01);
    check("rd_ram_addr", ram_addr, 4'd4);
    cyc(0, 2'b00, 2'b00, 2'b00, 4'd0, 4'h0, 4'd0, 4'h0);
    check("rd_rvalid", rvalid, 2'b01);
    check("rd_rdata", rdata, 4'h5);
    check("rd_idle_gnt", gnt, 2'b00);

    // Contention from a fresh reset: port 0 first, then alternate
    cyc(1, 2'b00, 2'b00, 2'b00, 4'd0, 4'h0, 4'd0, 4'h0);
    cyc(0, 2'b11, 2'b00, 2'b00, 4'd4, 4'h0, 4'd5, 4'h0);
    check("rr_gnt0", gnt, 2'b01);
    cyc(0, 2'b11, 2'b00, 2'b00, 4'd4, 4'h0, 4'd5, 4'h0);
    check("rr_gnt1", gnt, 2'b10);
    check("rr_rvalid1", rvalid, 2'b01);
    check("rr_rdata1", rdata, 4'h5);
    cyc(0, 2'b11, 2'b00, 2'b00, 4'd4, 4'h0, 4'd5, 4'h0);
    check("rr_gnt2", gnt, 2'b01);
    check("rr_rvalid2", rvalid, 2'b10);
    check("rr_rdata2", rdata, 4'hA);
    cyc(0, 2'b11, 2'b00, 2'b00, 4'd4, 4'h0, 4'd5, 4'h0);
    check("rr_gnt3", gnt, 2'b10);
    cyc(0, 2'b00, 2'b00, 2'b00, 4'd0, 4'h0, 4'd0, 4'h0);
    check("rr_rvalid4", rvalid, 2'b10);
    check("rr_rdata4", rdata, 4'hA);

    // Atomic ADD: port 0 locked read, idle, then releasing write; port 1 writes 0 throughout
    cyc(0, 2'b11, 2'b01, 2'b10, 4'd4, 4'h0, 4'd4, 4'h0);
    check("add_rd_gnt", gnt, 2'b01);
    cyc(0, 2'b10, 2'b00, 2'b10, 4'd4, 4'h0, 4'd4, 4'h0);
    check("add_wait_gnt", gnt, 2'b00);
    check("add_rvalid", rvalid, 2'b01);
    check("add_rdata", rdata, 4'h5);
    cyc(0, 2'b11, 2'b00, 2'b11, 4'd4, 4'hB, 4'd4, 4'h0);
    check("add_wr_gnt", gnt, 2'b01);
    check("add_wr_data", ram_wdata, 4'hB);
    cyc(0, 2'b10, 2'b00, 2'b10, 4'd4, 4'h0, 4'd4, 4'h0);
    check("add_p1_gnt", gnt, 2'b10);
    cyc(0, 2'b01, 2'b00, 2'b00, 4'd4, 4'h0, 4'd0, 4'h0);
    check("add_chk_gnt", gnt, 2'b01);
    cyc(0, 2'b00, 2'b00, 2'b00, 4'd0, 4'h0, 4'd0, 4'h0);
    check("add_final_rdata", rdata, 4'h0);
    check("add_lock_err", lock_err, 1'b0);

    // Watchdog: port 0 locks and goes idle, port 1 waits LOCK_MAX locked cycles
    cyc(0, 2'b01, 2'b01, 2'b00, 4'd4, 4'h0, 4'd0, 4'h0);
    check("wd_lock_gnt", gnt, 2'b01);
    for (int i = 1; i <= 8; i++) begin
      cyc(0, 2'b10, 2'b00, 2'b00, 4'd0, 4'h0, 4'd5, 4'h0);
      check($sformatf("wd_wait_gnt%0d", i), gnt, 2'b00);
      check($sformatf("wd_wait_err%0d", i), lock_err, 1'b0);
    end
    cyc(0, 2'b10, 2'b00, 2'b00, 4'd0, 4'h0, 4'd5, 4'h0);
    check("wd_err_pulse", lock_err, 1'b1);
    check("wd_p1_gnt", gnt, 2'b10);
    cyc(0, 2'b00, 2'b00, 2'b00, 4'd0, 4'h0, 4'd0, 4'h0);
    check("wd_err_once", lock_err, 1'b0);
    check("wd_rdata", rdata, 4'hA);

    // Release in the same cycle the watchdog would expire: no pulse
    cyc(0, 2'b01, 2'b01, 2'b00, 4'd4, 4'h0, 4'd0, 4'h0);
    check("rel_lock_gnt", gnt, 2'b01);
    for (int i = 1; i <= 7; i++) cyc(0, 2'b00, 2'b00, 2'b00, 4'd0, 4'h0, 4'd0, 4'h0);
    cyc(0, 2'b11, 2'b00, 2'b00, 4'd4, 4'h0, 4'd5, 4'h0);
    check("rel_owner_gnt", gnt, 2'b01);
    cyc(0, 2'b10, 2'b00, 2'b00, 4'd0, 4'h0, 4'd5, 4'h0);
    check("rel_no_err", lock_err, 1'b0);
    check("rel_p1_gnt", gnt, 2'b10);

    // Reset mid-lock with a read pending; the loader write during reset is dropped
    cyc(0, 2'b01, 2'b01, 2'b00, 4'd5, 4'h0, 4'd0, 4'h0);
    check("mr_lock_gnt", gnt, 2'b01);
    cyc(1, 2'b11, 2'b00, 2'b10, 4'd5, 4'h0, 4'd6, 4'h3);
    check("mr_rst_gnt", gnt, 2'b00);
    check("mr_rst_rvalid", rvalid, 2'b00);
    check("mr_rst_ram_en", ram_en, 1'b0);
    cyc(0, 2'b10, 2'b00, 2'b00, 4'd0, 4'h0, 4'd6, 4'h0);
    check("mr_p1_gnt", gnt, 2'b10);
    check("mr_err0", lock_err, 1'b0);
    cyc(0, 2'b00, 2'b00, 2'b00, 4'd0, 4'h0, 4'd0, 4'h0);
    check("mr_rvalid", rvalid, 2'b10);
    check("mr_rdata", rdata, 4'h7);
    for (int i = 0; i < 9; i++) begin
      cyc(0, 2'b00, 2'b00, 2'b00, 4'd0, 4'h0, 4'd0, 4'h0);
      check($sformatf("mr_no_err%0d", i), lock_err, 1'b0);
    end

    // Loader write then core read of the same address
    cyc(0, 2'b10, 2'b00, 2'b10, 4'd0, 4'h0, 4'd15, 4'hF);
    check("wr15_gnt", gnt, 2'b10);
    check("wr15_ram_we", ram_we, 1'b1);
    cyc(0, 2'b01, 2'b00, 2'b00, 4'd15, 4'h0, 4'd0, 4'h0);
    check("rd15_gnt", gnt, 2'b01);
    check("rd15_no_rvalid", rvalid, 2'b00);
    cyc(0, 2'b00, 2'b00, 2'b00, 4'd0, 4'h0, 4'd0, 4'h0);
    check("rd15_rvalid", rvalid, 2'b01);
    check("rd15_rdata", rdata, 4'hF);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
